// File: rtl/multicycle_alu_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_alu_controller_if
//  Description : Bundle between the multicycle controller and the RV32I
//                datapath: instruction fields and the ALU zero flag in,
//                ALU opcode, enables and mux selects out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_alu_controller_if;
  logic [6:0] Opcode;
  logic [2:0] Func3;
  logic       Func7b5;
  logic       ZeroFlag;
  logic [2:0] AluOpcode;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] AluSrcA;
  logic [1:0] AluSrcB;
  logic [2:0] ImmSrc;
  logic       Illegal;

  // Controller side
  modport master (
    input  Opcode, Func3, Func7b5, ZeroFlag,
    output AluOpcode, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
           ResultSrc, AluSrcA, AluSrcB, ImmSrc, Illegal
  );

  // Datapath side
  modport slave (
    output Opcode, Func3, Func7b5, ZeroFlag,
    input  AluOpcode, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
           ResultSrc, AluSrcA, AluSrcB, ImmSrc, Illegal
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_alu_controller.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_alu_controller
//  Description : Multicycle RV32I control FSM. One state per clock; all
//                outputs are decoded combinationally from the current state
//                and the instruction fields / ALU zero flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_alu_controller #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  wire logic                   clk,
  input  wire logic                   rst_n,
  multicycle_alu_controller_if.master bus
);

  localparam logic [6:0] c_OP_R    = 7'b0110011;
  localparam logic [6:0] c_OP_I    = 7'b0010011;
  localparam logic [6:0] c_OP_LW   = 7'b0000011;
  localparam logic [6:0] c_OP_SW   = 7'b0100011;
  localparam logic [6:0] c_OP_BR   = 7'b1100011;
  localparam logic [6:0] c_OP_JAL  = 7'b1101111;
  localparam logic [6:0] c_OP_JALR = 7'b1100111;
  localparam logic [6:0] c_OP_LUI  = 7'b0110111;

  localparam logic [2:0] c_ALU_ADD  = 3'b000;
  localparam logic [2:0] c_ALU_SUB  = 3'b001;
  localparam logic [2:0] c_ALU_AND  = 3'b010;
  localparam logic [2:0] c_ALU_OR   = 3'b011;
  localparam logic [2:0] c_ALU_SLTU = 3'b100;
  localparam logic [2:0] c_ALU_SLT  = 3'b101;
  localparam logic [2:0] c_ALU_XOR  = 3'b110;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR1    = 4'd11,
    S_JALR2    = 4'd12,
    S_LUI      = 4'd13
  } state_t;

  state_t r_state;
  state_t w_cur;

  logic [2:0] w_aluop;
  logic       w_pcwrite;
  logic       w_adrsrc;
  logic       w_memwrite;
  logic       w_irwrite;
  logic       w_regwrite;
  logic [1:0] w_resultsrc;
  logic [1:0] w_alusrca;
  logic [1:0] w_alusrcb;
  logic [2:0] w_immsrc;
  logic       w_illegal;

  // Func3-based ALU operation; SUB only for R-type with Func7b5 set,
  // shift encodings (001/101) decode as ADD.
  function automatic logic [2:0] f_alu_decode(input logic [2:0] f3,
                                              input logic       f7b5,
                                              input logic       is_r);
    case (f3)
      3'b000:  f_alu_decode = (is_r && f7b5) ? c_ALU_SUB : c_ALU_ADD;
      3'b010:  f_alu_decode = c_ALU_SLT;
      3'b011:  f_alu_decode = c_ALU_SLTU;
      3'b100:  f_alu_decode = c_ALU_XOR;
      3'b110:  f_alu_decode = c_ALU_OR;
      3'b111:  f_alu_decode = c_ALU_AND;
      default: f_alu_decode = c_ALU_ADD;
    endcase
  endfunction

  // State register with async clear; next state chosen per current state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= state_t'(RESET_STATE);
    end else begin
      case (r_state)
        S_FETCH:  r_state <= S_DECODE;
        S_DECODE: begin
          case (bus.Opcode)
            c_OP_LW,
            c_OP_SW:   r_state <= S_MEMADR;
            c_OP_R:    r_state <= S_EXECR;
            c_OP_I:    r_state <= S_EXECI;
            c_OP_BR:   r_state <= S_BRANCH;
            c_OP_JAL:  r_state <= S_JAL;
            c_OP_JALR: r_state <= S_JALR1;
            c_OP_LUI:  r_state <= S_LUI;
            default:   r_state <= S_FETCH;
          endcase
        end
        S_MEMADR:   r_state <= (bus.Opcode == c_OP_SW) ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  r_state <= S_MEMWB;
        S_EXECR,
        S_EXECI,
        S_JAL,
        S_JALR2:    r_state <= S_ALUWB;
        S_JALR1:    r_state <= S_JALR2;
        default:    r_state <= S_FETCH;
      endcase
    end
  end

  // While reset is held the selects must show their FETCH values
  assign w_cur = rst_n ? r_state : S_FETCH;

  // Immediate format depends only on the opcode, in every state
  always_comb begin
    case (bus.Opcode)
      c_OP_SW:  w_immsrc = 3'b001;
      c_OP_BR:  w_immsrc = 3'b010;
      c_OP_JAL: w_immsrc = 3'b011;
      c_OP_LUI: w_immsrc = 3'b100;
      default:  w_immsrc = 3'b000;
    endcase
  end

  // Per-state control word; anything not listed stays at 0 / ADD
  always_comb begin
    w_aluop     = c_ALU_ADD;
    w_pcwrite   = 1'b0;
    w_adrsrc    = 1'b0;
    w_memwrite  = 1'b0;
    w_irwrite   = 1'b0;
    w_regwrite  = 1'b0;
    w_resultsrc = 2'b00;
    w_alusrca   = 2'b00;
    w_alusrcb   = 2'b00;
    w_illegal   = 1'b0;
    case (w_cur)
      S_FETCH: begin
        w_irwrite   = 1'b1;
        w_pcwrite   = 1'b1;
        w_alusrcb   = 2'b10;
        w_resultsrc = 2'b10;
      end
      S_DECODE: begin
        w_alusrca = 2'b01;
        w_alusrcb = 2'b01;
        case (bus.Opcode)
          c_OP_R, c_OP_I, c_OP_LW, c_OP_SW, c_OP_BR,
          c_OP_JAL, c_OP_JALR, c_OP_LUI: w_illegal = 1'b0;
          default:                       w_illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        w_alusrca = 2'b10;
        w_alusrcb = 2'b01;
      end
      S_MEMREAD: w_adrsrc = 1'b1;
      S_MEMWB: begin
        w_resultsrc = 2'b01;
        w_regwrite  = 1'b1;
      end
      S_MEMWRITE: begin
        w_adrsrc   = 1'b1;
        w_memwrite = 1'b1;
      end
      S_EXECR: begin
        w_alusrca = 2'b10;
        w_aluop   = f_alu_decode(bus.Func3, bus.Func7b5, 1'b1);
      end
      S_EXECI: begin
        w_alusrca = 2'b10;
        w_alusrcb = 2'b01;
        w_aluop   = f_alu_decode(bus.Func3, bus.Func7b5, 1'b0);
      end
      S_ALUWB: w_regwrite = 1'b1;
      S_BRANCH: begin
        w_alusrca = 2'b10;
        case (bus.Func3)
          3'b000: begin w_aluop = c_ALU_SUB; w_pcwrite =  bus.ZeroFlag; end
          3'b001: begin w_aluop = c_ALU_SUB; w_pcwrite = ~bus.ZeroFlag; end
          3'b100: begin w_aluop = c_ALU_SLT; w_pcwrite = ~bus.ZeroFlag; end
          3'b101: begin w_aluop = c_ALU_SLT; w_pcwrite =  bus.ZeroFlag; end
          default: w_pcwrite = 1'b0;
        endcase
      end
      S_JAL, S_JALR2: begin
        w_alusrca = 2'b01;
        w_alusrcb = 2'b10;
        w_pcwrite = 1'b1;
      end
      S_JALR1: begin
        w_alusrca = 2'b10;
        w_alusrcb = 2'b01;
      end
      S_LUI: begin
        w_resultsrc = 2'b11;
        w_regwrite  = 1'b1;
      end
      default: w_aluop = c_ALU_ADD;
    endcase
  end

  // Write enables are gated by reset so nothing writes while it is asserted
  assign bus.AluOpcode = w_aluop;
  assign bus.PCWrite   = w_pcwrite  & rst_n;
  assign bus.AdrSrc    = w_adrsrc;
  assign bus.MemWrite  = w_memwrite & rst_n;
  assign bus.IRWrite   = w_irwrite  & rst_n;
  assign bus.RegWrite  = w_regwrite & rst_n;
  assign bus.ResultSrc = w_resultsrc;
  assign bus.AluSrcA   = w_alusrca;
  assign bus.AluSrcB   = w_alusrcb;
  assign bus.ImmSrc    = w_immsrc;
  assign bus.Illegal   = w_illegal  & rst_n;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_alu_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_alu_controller
//  Description : Directed bench for the multicycle controller. A per-cycle
//                control word is predicted from the instruction class and
//                the cycle index within the instruction.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_alu_controller;

  localparam logic [6:0] c_R = 7'b0110011, c_I = 7'b0010011, c_LW = 7'b0000011,
                         c_SW = 7'b0100011, c_BR = 7'b1100011, c_JAL = 7'b1101111,
                         c_JALR = 7'b1100111, c_LUI = 7'b0110111, c_BAD = 7'b1111111;

  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BR = 4,
                 K_JAL = 5, K_JALR = 6, K_LUI = 7, K_BAD = 8;

  typedef struct packed {
    logic [2:0] alu;
    logic       pcw;
    logic       adr;
    logic       mw;
    logic       irw;
    logic       rw;
    logic [1:0] rs;
    logic [1:0] a;
    logic [1:0] b;
    logic [2:0] imm;
    logic       ill;
  } ctl_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  multicycle_alu_controller_if bus ();

  multicycle_alu_controller #(.RESET_STATE(4'd0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  ctl_t dut_ctl;
  ctl_t exp_ctl;
  logic exp_valid = 1'b0;
  ctl_t obs [0:7];
  int   checks = 0;
  int   failures = 0;

  always_comb begin
    dut_ctl.alu = bus.AluOpcode;
    dut_ctl.pcw = bus.PCWrite;
    dut_ctl.adr = bus.AdrSrc;
    dut_ctl.mw  = bus.MemWrite;
    dut_ctl.irw = bus.IRWrite;
    dut_ctl.rw  = bus.RegWrite;
    dut_ctl.rs  = bus.ResultSrc;
    dut_ctl.a   = bus.AluSrcA;
    dut_ctl.b   = bus.AluSrcB;
    dut_ctl.imm = bus.ImmSrc;
    dut_ctl.ill = bus.Illegal;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, want, $time);
    end
  endtask

  function automatic int cls_of(input logic [6:0] op);
    case (op)
      c_R:     return K_R;
      c_I:     return K_I;
      c_LW:    return K_LW;
      c_SW:    return K_SW;
      c_BR:    return K_BR;
      c_JAL:   return K_JAL;
      c_JALR:  return K_JALR;
      c_LUI:   return K_LUI;
      default: return K_BAD;
    endcase
  endfunction

  // Cycles per instruction, FETCH inclusive
  function automatic int latency(input int k);
    case (k)
      K_R, K_I, K_SW, K_JAL: return 4;
      K_LW, K_JALR:          return 5;
      K_BR, K_LUI:           return 3;
      default:               return 2;
    endcase
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    case (cls_of(op))
      K_SW:    return 3'b001;
      K_BR:    return 3'b010;
      K_JAL:   return 3'b011;
      K_LUI:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // ALU codes: ADD 0, SUB 1, AND 2, OR 3, SLTU 4, SLT 5, XOR 6
  function automatic logic [2:0] alu_of(input logic [2:0] f3, input logic f7, input logic is_r);
    case (f3)
      3'd0:    return (is_r && f7) ? 3'd1 : 3'd0;
      3'd2:    return 3'd5;
      3'd3:    return 3'd4;
      3'd4:    return 3'd6;
      3'd6:    return 3'd3;
      3'd7:    return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  // Expected control word for cycle 'step' of an instruction
  function automatic ctl_t model(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                 input logic z, input int step, input logic rstn);
    ctl_t c;
    int   k;
    c     = '0;
    k     = cls_of(op);
    c.imm = imm_of(op);
    if (!rstn || step == 0) begin
      c.b  = 2'd2;
      c.rs = 2'd2;
      c.irw = rstn;
      c.pcw = rstn;
      return c;
    end
    if (step == 1) begin
      c.a   = 2'd1;
      c.b   = 2'd1;
      c.ill = (k == K_BAD);
      return c;
    end
    case (k)
      K_LW: begin
        if (step == 2) begin c.a = 2'd2; c.b = 2'd1; end
        if (step == 3) c.adr = 1'b1;
        if (step == 4) begin c.rs = 2'd1; c.rw = 1'b1; end
      end
      K_SW: begin
        if (step == 2) begin c.a = 2'd2; c.b = 2'd1; end
        if (step == 3) begin c.adr = 1'b1; c.mw = 1'b1; end
      end
      K_R, K_I: begin
        if (step == 2) begin
          c.a   = 2'd2;
          c.b   = (k == K_I) ? 2'd1 : 2'd0;
          c.alu = alu_of(f3, f7, k == K_R);
        end
        if (step == 3) c.rw = 1'b1;
      end
      K_BR: begin
        c.a = 2'd2;
        case (f3)
          3'd0:    begin c.alu = 3'd1; c.pcw = z;  end
          3'd1:    begin c.alu = 3'd1; c.pcw = !z; end
          3'd4:    begin c.alu = 3'd5; c.pcw = !z; end
          3'd5:    begin c.alu = 3'd5; c.pcw = z;  end
          default: c.pcw = 1'b0;
        endcase
      end
      K_JAL: begin
        if (step == 2) begin c.a = 2'd1; c.b = 2'd2; c.pcw = 1'b1; end
        if (step == 3) c.rw = 1'b1;
      end
      K_JALR: begin
        if (step == 2) begin c.a = 2'd2; c.b = 2'd1; end
        if (step == 3) begin c.a = 2'd1; c.b = 2'd2; c.pcw = 1'b1; end
        if (step == 4) c.rw = 1'b1;
      end
      K_LUI: begin
        c.rs = 2'd3;
        c.rw = 1'b1;
      end
      default: c = c;
    endcase
    return c;
  endfunction

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (exp_valid) chk("ctl", 32'(dut_ctl), 32'(exp_ctl));
  end

  // One instruction, cycle by cycle; abort_at >= 0 drops reset mid-cycle there
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic zbr, input int abort_at);
    int lat;
    lat = latency(cls_of(op));
    for (int s = 0; s < lat; s++) begin
      @(posedge clk);
      #1;
      rst_n        = 1'b1;
      bus.Opcode   = op;
      bus.Func3    = f3;
      bus.Func7b5  = f7;
      bus.ZeroFlag = (s == 2) ? zbr : ~zbr;
      exp_ctl      = model(op, f3, f7, bus.ZeroFlag, s, 1'b1);
      exp_valid    = 1'b1;
      #2;
      obs[s] = dut_ctl;
      if (s == abort_at) begin
        @(negedge clk);
        #1;
        rst_n   = 1'b0;
        exp_ctl = model(op, f3, f7, bus.ZeroFlag, s, 1'b0);
        #1;
        chk("mw_fall_on_reset", 32'(bus.MemWrite), 32'd0);
        break;
      end
    end
  endtask

  initial begin
    bus.Opcode   = c_R;
    bus.Func3    = 3'd0;
    bus.Func7b5  = 1'b0;
    bus.ZeroFlag = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      exp_ctl   = model(c_R, 3'd0, 1'b0, 1'b0, 0, 1'b0);
      exp_valid = 1'b1;
      #2;
      chk("reset_enables", 32'({bus.PCWrite, bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.Illegal}), 32'd0);
    end

    // R-type sub
    run_instr(c_R, 3'd0, 1'b1, 1'b0, -1);
    chk("first_fetch_irw_pcw_b", 32'({obs[0].irw, obs[0].pcw, obs[0].b}), 32'b1110);
    chk("sub_aluop", 32'(obs[2].alu), 32'd1);
    chk("sub_regwrite_seq", 32'({obs[0].rw, obs[1].rw, obs[2].rw, obs[3].rw}), 32'b0001);

    // LW then SW back to back
    run_instr(c_LW, 3'd2, 1'b0, 1'b0, -1);
    chk("lw_memwrite_seq", 32'({obs[0].mw, obs[1].mw, obs[2].mw, obs[3].mw, obs[4].mw}), 32'd0);
    chk("lw_regwrite_seq", 32'({obs[0].rw, obs[1].rw, obs[2].rw, obs[3].rw, obs[4].rw}), 32'b00001);
    chk("lw_resultsrc_c5", 32'(obs[4].rs), 32'd1);
    run_instr(c_SW, 3'd2, 1'b0, 1'b0, -1);
    chk("sw_memwrite_seq", 32'({obs[0].mw, obs[1].mw, obs[2].mw, obs[3].mw}), 32'b0001);
    chk("sw_adrsrc_c4", 32'(obs[3].adr), 32'd1);

    // Branches
    run_instr(c_BR, 3'd0, 1'b0, 1'b1, -1);
    chk("beq_z1_pcw", 32'(obs[2].pcw), 32'd1);
    run_instr(c_BR, 3'd1, 1'b0, 1'b1, -1);
    chk("bne_z1_pcw", 32'(obs[2].pcw), 32'd0);
    run_instr(c_BR, 3'd4, 1'b0, 1'b0, -1);
    chk("blt_z0_alu_pcw", 32'({obs[2].alu, obs[2].pcw}), 32'b1011);
    run_instr(c_BR, 3'd5, 1'b0, 1'b0, -1);
    run_instr(c_BR, 3'd6, 1'b0, 1'b1, -1);
    chk("bltu_unsupported_pcw", 32'(obs[2].pcw), 32'd0);

    // JALR
    run_instr(c_JALR, 3'd0, 1'b0, 1'b0, -1);
    chk("jalr1_srca", 32'(obs[2].a), 32'd2);
    chk("jalr2_pcw", 32'(obs[3].pcw), 32'd1);
    chk("jalr_wb_c5", 32'(obs[4].rw), 32'd1);
    chk("jalr_immsrc", 32'(obs[0].imm | obs[1].imm | obs[2].imm | obs[3].imm | obs[4].imm), 32'd0);

    // I-type and other decodes
    run_instr(c_I, 3'd4, 1'b0, 1'b1, -1);
    chk("xori_alu", 32'(obs[2].alu), 32'd6);
    run_instr(c_I, 3'd0, 1'b1, 1'b0, -1);
    chk("addi_f7_alu", 32'(obs[2].alu), 32'd0);
    run_instr(c_I, 3'd1, 1'b0, 1'b0, -1);
    run_instr(c_R, 3'd7, 1'b0, 1'b0, -1);
    chk("and_alu", 32'(obs[2].alu), 32'd2);
    run_instr(c_R, 3'd3, 1'b0, 1'b0, -1);
    run_instr(c_JAL, 3'd0, 1'b0, 1'b0, -1);
    chk("jal_imm_pcw", 32'({obs[2].imm, obs[2].pcw}), 32'b0111);
    run_instr(c_LUI, 3'd0, 1'b0, 1'b0, -1);
    chk("lui_rs_rw", 32'({obs[2].rs, obs[2].rw}), 32'b111);

    // Unsupported opcode
    run_instr(c_BAD, 3'd0, 1'b0, 1'b0, -1);
    chk("illegal_pulse", 32'({obs[0].ill, obs[1].ill}), 32'b01);
    chk("illegal_no_writes", 32'({obs[1].pcw, obs[1].mw, obs[1].irw, obs[1].rw}), 32'd0);

    // Reset dropped during MEMWRITE, held one more cycle, then restart
    run_instr(c_SW, 3'd2, 1'b0, 1'b0, 3);
    chk("sw_memwrite_before_reset", 32'(obs[3].mw), 32'd1);
    @(posedge clk);
    #3;
    chk("held_reset_enables", 32'({bus.PCWrite, bus.MemWrite, bus.IRWrite, bus.RegWrite}), 32'd0);
    run_instr(c_R, 3'd0, 1'b0, 1'b0, -1);
    chk("restart_fetch", 32'({obs[0].irw, obs[0].pcw}), 32'b11);

    #3;
    exp_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
